// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
//   Issue-side companion of the ALU. Accepts one instruction word at a time
//   over a valid/ready handshake. It decodes the word and reads two operands
//   from an internal register file. It then drives the ALU ports, captures
//   the ALU result and flags, and writes them back. One instruction takes
//   four cycles: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
//
//   Handshake: an instruction is transferred on a rising clock edge where
//   instr_valid and instr_ready are both high. instr_ready is high only in
//   IDLE. The producer may hold instr_valid high for as long as it likes.
//
//   Optional feature: define ALU_SEQ_IMM_EN to build the immediate operand
//   mux. When it is built, instr[2]=1 replaces reg[rs2] with the
//   zero-extended value of instr[5:3].
//
// Instruction word:
//   [15:12] opcode  [11:9] rd  [8:6] rs1  [5:3] rs2  [2] imm sel  [1:0] rsvd
//
// Ports:
//   clock, reset             single clock; synchronous active-high reset
//   instr_valid/ready/instr  instruction handshake
//   load_en/addr/data        register preload, honoured only in IDLE
//   alu_primary/secondary    operands to the ALU, registered in DECODE
//   alu_operation            opcode to the ALU, registered in DECODE
//   alu_result/alu_flags     combinational ALU outputs
//   status_flags             architectural flags {V,Z,C,N} = bits {3,2,1,0}
//   done                     one-cycle pulse in WRITEBACK
//   illegal                  pulses together with done for unknown opcodes
//   dbg_addr/dbg_data        combinational register file read port
//
// Opcode codes: ADD=0, SUBTRACT=1, AND=2, OR=3, COMPLEMENT=4.
// ----------------------------------------------------------------------------
module alu_sequencer #(
   parameter int SIZE  = 16,
   parameter int NREGS = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [15:0]     instr,
   input  logic            load_en,
   input  logic [2:0]      load_addr,
   input  logic [SIZE-1:0] load_data,
   output logic [SIZE-1:0] alu_primary,
   output logic [SIZE-1:0] alu_secondary,
   output logic [3:0]      alu_operation,
   input  logic [SIZE-1:0] alu_result,
   input  logic [3:0]      alu_flags,
   output logic [3:0]      status_flags,
   output logic            done,
   output logic            illegal,
   input  logic [2:0]      dbg_addr,
   output logic [SIZE-1:0] dbg_data
);

   localparam logic [3:0] ALU_ADD        = 4'h0;
   localparam logic [3:0] ALU_SUBTRACT   = 4'h1;
   localparam logic [3:0] ALU_AND        = 4'h2;
   localparam logic [3:0] ALU_OR         = 4'h3;
   localparam logic [3:0] ALU_COMPLEMENT = 4'h4;
   localparam int         OVERFLOWFLAG   = 3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DECODE    = 2'd1,
      EXECUTE   = 2'd2,
      WRITEBACK = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [3:0]      op_q;
   logic [2:0]      rd_q;
   logic [2:0]      rs1_q;
   logic [2:0]      rs2_q;
   logic [SIZE-1:0] result_q;
   logic [3:0]      flags_q;
   logic [SIZE-1:0] regs [NREGS];
   logic [SIZE-1:0] operand_b;
   logic [3:0]      flags_wb;
   logic            op_legal;
   logic            accept;
   logic            unused_instr_bits;

   assign accept = (state == IDLE) && instr_valid;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (instr_valid) state_next = DECODE;
         DECODE:    state_next = EXECUTE;
         EXECUTE:   state_next = WRITEBACK;
         WRITEBACK: state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      instr_ready = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
      case (state)
         IDLE:      instr_ready = 1'b1;
         WRITEBACK: begin
            done    = 1'b1;
            illegal = ~op_legal;
         end
         default: ;
      endcase
   end

   // ---------------- decode ----------------
   assign op_legal = (op_q == ALU_ADD) || (op_q == ALU_SUBTRACT) ||
                     (op_q == ALU_AND) || (op_q == ALU_OR) ||
                     (op_q == ALU_COMPLEMENT);

   // The overflow flag only has meaning for ADD. Every other op clears it.
   always_comb begin
      flags_wb = flags_q;
      if (op_q != ALU_ADD) flags_wb[OVERFLOWFLAG] = 1'b0;
   end

`ifdef ALU_SEQ_IMM_EN
   logic imm_q;

   always_ff @(posedge clock) begin
      if (reset)       imm_q <= 1'b0;
      else if (accept) imm_q <= instr[2];
   end

   assign operand_b         = imm_q ? SIZE'(rs2_q) : regs[rs2_q];
   assign unused_instr_bits = &{1'b0, instr[1:0]};
`else
   assign operand_b         = regs[rs2_q];
   assign unused_instr_bits = &{1'b0, instr[2:0]};
`endif

   // Instruction latch
   always_ff @(posedge clock) begin
      if (reset) begin
         op_q  <= '0;
         rd_q  <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
      end else if (accept) begin
         op_q  <= instr[15:12];
         rd_q  <= instr[11:9];
         rs1_q <= instr[8:6];
         rs2_q <= instr[5:3];
      end
   end

   // ALU operand ports change only on the DECODE edge and hold otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         alu_primary   <= '0;
         alu_secondary <= '0;
         alu_operation <= '0;
      end else if (state == DECODE) begin
         alu_primary   <= regs[rs1_q];
         alu_secondary <= operand_b;
         alu_operation <= op_q;
      end
   end

   // ALU output capture at the end of EXECUTE
   always_ff @(posedge clock) begin
      if (reset) begin
         result_q <= '0;
         flags_q  <= '0;
      end else if (state == EXECUTE) begin
         result_q <= alu_result;
         flags_q  <= alu_flags;
      end
   end

   // Architectural flags
   always_ff @(posedge clock) begin
      if (reset)                               status_flags <= '0;
      else if (state == WRITEBACK && op_legal) status_flags <= flags_wb;
   end

   // Register file. A preload can only happen in IDLE and a writeback only
   // in WRITEBACK, so the two write ports never collide. A preload in the
   // accepting IDLE cycle is visible to the DECODE read that follows.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (state == IDLE && load_en) begin
         regs[load_addr] <= load_data;
      end else if (state == WRITEBACK && op_legal) begin
         regs[rd_q] <= result_q;
      end
   end

   assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_COMP = 4'h4;
  localparam int FV = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FN = 0;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        load_en;
  logic [2:0]  load_addr;
  logic [15:0] load_data;
  logic [15:0] alu_primary;
  logic [15:0] alu_secondary;
  logic [3:0]  alu_operation;
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic [3:0]  status_flags;
  logic        done;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  alu_sequencer #(.SIZE(16), .NREGS(8)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .alu_primary(alu_primary), .alu_secondary(alu_secondary),
    .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .status_flags(status_flags), .done(done), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // clock / reset
  always #5 clock = ~clock;

  // Reference ALU behaviour: returns {flags, result}.
  function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] wide;
    logic [15:0] r;
    logic [3:0]  f;
    f = 4'h0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        r     = wide[15:0];
        f[FC] = wide[16];
        f[FV] = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB: begin
        r     = a - b;
        f[FC] = (a < b);
        f[FV] = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_COMP: r = ~a;
      default: begin
        r = 16'hFFFF;
        f = 4'hF;
      end
    endcase
    if (op <= OP_COMP) begin
      f[FZ] = (r == 16'h0000);
      f[FN] = r[15];
    end
    return {f, r};
  endfunction

  // ALU attached to the DUT
  always_comb {alu_flags, alu_result} = alu_fn(alu_operation, alu_primary, alu_secondary);

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic imm);
    return {op, rd, rs1, rs2, imm, 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: an instruction occupies the sequencer for its accept
  // cycle plus three more; its result lands at the end of the last one.
  logic [15:0] m_reg [8];
  logic [3:0]  m_flags;
  int          m_busy;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_op;
  logic [15:0] p_a, p_b, p_res;
  logic [3:0]  p_op, p_f;
  logic [2:0]  p_rd;
  logic        p_legal;
  logic        model_live = 1'b0;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
      m_flags = 4'h0; m_busy = 0; m_a = 16'h0; m_b = 16'h0; m_op = 4'h0;
      model_live = 1'b1;
    end else if (m_busy == 0) begin
      if (load_en) m_reg[load_addr] = load_data;
      if (instr_valid) begin
        p_op = instr[15:12];
        p_rd = instr[11:9];
        p_a  = m_reg[instr[8:6]];
`ifdef ALU_SEQ_IMM_EN
        p_b  = instr[2] ? {13'h0, instr[5:3]} : m_reg[instr[5:3]];
`else
        p_b  = m_reg[instr[5:3]];
`endif
        {p_f, p_res} = alu_fn(p_op, p_a, p_b);
        p_legal = (p_op <= OP_COMP);
        if (p_op != OP_ADD) p_f[FV] = 1'b0;
        m_busy = 3;
      end
    end else begin
      if (m_busy == 3) begin
        m_a = p_a; m_b = p_b; m_op = p_op;
      end
      if (m_busy == 1 && p_legal) begin
        m_reg[p_rd] = p_res;
        m_flags = p_f;
      end
      m_busy--;
    end
  end

  // Compare process: every cycle once reset has been seen.
  always @(negedge clock) begin
    if (model_live) begin
      check("ready",     32'(instr_ready),   32'(m_busy == 0));
      check("done",      32'(done),          32'(m_busy == 1));
      check("illegal",   32'(illegal),       32'(m_busy == 1 && !p_legal));
      check("status",    32'(status_flags),  32'(m_flags));
      check("primary",   32'(alu_primary),   32'(m_a));
      check("secondary", 32'(alu_secondary), 32'(m_b));
      check("operation", 32'(alu_operation), 32'(m_op));
      check("dbg_data",  32'(dbg_data),      32'(m_reg[dbg_addr]));
    end
  end

  // driver tasks (all start and end at posedge + #1)
  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic issue(input logic [15:0] w, input bit hold, output int acc_cycle);
    bit rdy;
    int c;
    bit ok;
    ok = 1'b0;
    acc_cycle = -1;
    instr = w; instr_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rdy = instr_ready;
      c   = cyc;
      step();
      if (rdy) begin
        acc_cycle = c; ok = 1'b1;
        break;
      end
    end
    if (!ok) check("issue_timeout", 0, 1);
    if (!hold) instr_valid = 1'b0;
  endtask

  // Waits for done, then steps past the writeback edge.
  task automatic wait_done(output int done_cycle, output logic ill);
    bit ok;
    ok = 1'b0;
    done_cycle = -1;
    ill = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        done_cycle = cyc; ill = illegal; ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check("done_timeout", 0, 1);
    step();
  endtask

  task automatic peek(input string name, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    int   acc, acc2, dc;
    logic ill;
    reset = 1'b1; instr_valid = 1'b0; instr = 16'h0;
    load_en = 1'b0; load_addr = 3'd0; load_data = 16'h0; dbg_addr = 3'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_ready",  32'(instr_ready),  32'd1);
    check("rst_status", 32'(status_flags), 32'd0);
    check("rst_done",   32'(done),         32'd0);

    // 1: 7FFF + 0001 overflows into the sign bit
    load(3'd1, 16'h7FFF);
    load(3'd2, 16'h0001);
    load(3'd5, 16'h1234);
    issue(enc(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0), 1'b0, acc);
    wait_done(dc, ill);
    // the accept cycle is the first of the four; done is in the fourth
    check("add_latency", 32'(dc - acc), 32'd3);
    check("add_illegal", 32'(ill), 32'd0);
    peek("add_r3", 3'd3, 16'h8000);
    check("add_flags", 32'(status_flags), 32'b1001);

    // 2: r2 - r2 = 0
    issue(enc(OP_SUB, 3'd4, 3'd2, 3'd2, 1'b0), 1'b0, acc);
    wait_done(dc, ill);
    peek("sub_r4", 3'd4, 16'h0000);
    check("sub_z", 32'(status_flags[FZ]), 32'd1);
    check("sub_v", 32'(status_flags[FV]), 32'd0);

    // 3: unknown opcode leaves r5 and flags alone
    issue(enc(4'hF, 3'd5, 3'd1, 3'd2, 1'b0), 1'b0, acc);
    wait_done(dc, ill);
    check("ill_pulse", 32'(ill), 32'd1);
    peek("ill_r5", 3'd5, 16'h1234);
    check("ill_flags", 32'(status_flags), 32'b0100);

    // remaining legal ops, rd overlapping a source
    issue(enc(OP_AND, 3'd6, 3'd1, 3'd5, 1'b0), 1'b0, acc);
    wait_done(dc, ill);
    peek("and_r6", 3'd6, 16'h1234);
    issue(enc(OP_OR, 3'd1, 3'd1, 3'd3, 1'b0), 1'b0, acc);
    wait_done(dc, ill);
    peek("or_r1", 3'd1, 16'hFFFF);
    issue(enc(OP_COMP, 3'd0, 3'd5, 3'd2, 1'b1), 1'b0, acc);
    wait_done(dc, ill);
    peek("comp_r0", 3'd0, 16'hEDCB);

    // 4: reset during EXECUTE aborts the instruction
    issue(enc(OP_ADD, 3'd6, 3'd1, 3'd2, 1'b0), 1'b0, acc);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_done",  32'(done),        32'd0);
    for (int i = 0; i < 8; i++) peek($sformatf("abort_r%0d", i), 3'(i), 16'h0000);
    repeat (4) step();

    // 5: back-to-back with valid held; preload while busy is dropped
    load(3'd1, 16'd3);
    load(3'd2, 16'd4);
    issue(enc(OP_ADD, 3'd1, 3'd1, 3'd2, 1'b0), 1'b1, acc);
    instr = enc(OP_ADD, 3'd2, 3'd1, 3'd2, 1'b0);
    load_en = 1'b1; load_addr = 3'd0; load_data = 16'hDEAD;
    step();
    step();
    load_en = 1'b0;
    issue(enc(OP_ADD, 3'd2, 3'd1, 3'd2, 1'b0), 1'b0, acc2);
    check("b2b_spacing", 32'(acc2 - acc), 32'd4);
    wait_done(dc, ill);
    peek("b2b_r1", 3'd1, 16'd7);
    peek("b2b_r2", 3'd2, 16'd11);
    peek("busy_load_r0", 3'd0, 16'h0000);

    // 6: immediate operand (instr[2] is ignored without the feature)
    load(3'd1, 16'h0005);
    issue(enc(OP_ADD, 3'd7, 3'd1, 3'd3, 1'b1), 1'b0, acc);
    wait_done(dc, ill);
`ifdef ALU_SEQ_IMM_EN
    peek("imm_r7", 3'd7, 16'h0008);
`else
    peek("imm_r7", 3'd7, 16'h0005);
`endif
    check("imm_z", 32'(status_flags[FZ]), 32'd0);

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
